snake_frame_scanner: RTL and testbench

SNAKE_FRAME_SCANNER -- requirements
Module: snake_frame_scanner

---
 rtl/snake_frame_scanner_if.sv | 14 +
 rtl/snake_frame_scanner.sv | 249 ++++++++++++++++++++++++
 tb/tb_snake_frame_scanner.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snake_frame_scanner_if.sv
// Row stream from the snake frame scanner to its downstream consumer.
// Master presents a row with row_valid; the slave accepts it with row_ready.
interface snake_frame_scanner_if #(
    parameter int GRID_W = 16
) ();
    logic [GRID_W-1:0] head_row;
    logic [GRID_W-1:0] body_row;
    logic [3:0]        row_idx;
    logic              row_valid;
    logic              row_ready;

    modport master (output head_row, body_row, row_idx, row_valid, input  row_ready);
    modport slave  (input  head_row, body_row, row_idx, row_valid, output row_ready);
endinterface

// File: rtl/snake_frame_scanner.sv
// Scans a GRID_W x GRID_H frame from the snake body controller one row at a time and
// hands each row downstream. Optional head tracking is built with SNAKE_SCAN_HEAD_TRACK_EN.
module snake_frame_scanner #(
    parameter int GRID_W   = 16,
    parameter int GRID_H   = 16,
    parameter int RESP_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [3:0]            x,
    output logic [3:0]            y,
    input  logic                  snakeHead,
    input  logic                  snakeBody,
    snake_frame_scanner_if.master row_if,
    output logic                  sync,
    output logic                  busy,
    output logic [3:0]            head_x,
    output logic [3:0]            head_y,
    output logic                  head_err
);

    // state   | meaning
    // IDLE    | waiting for start
    // SCAN    | issuing x = 0..GRID_W-1 on the current row
    // DRAIN   | waiting for the last responses to leave the pipeline
    // PRESENT | row held on row_if until row_ready
    // DONE    | one-cycle sync pulse, then IDLE
    typedef enum logic [2:0] {IDLE, SCAN, DRAIN, PRESENT, DONE} state_t;

    localparam logic [3:0] X_LAST = 4'(GRID_W - 1);
    localparam logic [3:0] Y_LAST = 4'(GRID_H - 1);

    state_t              state_q, state_d;
    logic [3:0]          x_q, x_d;
    logic [3:0]          y_q, y_d;
    logic [3:0]          row_cnt_q, row_cnt_d;
    logic [3:0]          row_idx_q, row_idx_d;
    logic [GRID_W-1:0]   head_row_q, head_row_d;
    logic [GRID_W-1:0]   body_row_q, body_row_d;
    logic [GRID_W-1:0]   shd_head_q, shd_head_d;
    logic [GRID_W-1:0]   shd_body_q, shd_body_d;
    logic                row_valid_q, row_valid_d;
    logic                sync_q, sync_d;
    logic [RESP_LAT-1:0] pipe_vld_q, pipe_vld_d;
    logic [3:0]          pipe_tag_q [RESP_LAT];
    logic [3:0]          pipe_tag_d [RESP_LAT];
    logic                pipe_inner;
    logic                emit_vld;
    logic [3:0]          emit_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            row_cnt_q   <= '0;
            row_idx_q   <= '0;
            head_row_q  <= '0;
            body_row_q  <= '0;
            shd_head_q  <= '0;
            shd_body_q  <= '0;
            row_valid_q <= 1'b0;
            sync_q      <= 1'b0;
            pipe_vld_q  <= '0;
            pipe_tag_q  <= '{default: '0};
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            row_cnt_q   <= row_cnt_d;
            row_idx_q   <= row_idx_d;
            head_row_q  <= head_row_d;
            body_row_q  <= body_row_d;
            shd_head_q  <= shd_head_d;
            shd_body_q  <= shd_body_d;
            row_valid_q <= row_valid_d;
            sync_q      <= sync_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_tag_q  <= pipe_tag_d;
        end
    end

    // Column tag travels alongside the query so the response lands in the right bit.
    always_comb begin
        pipe_vld_d    = '0;
        pipe_tag_d    = '{default: '0};
        pipe_vld_d[0] = (state_q == SCAN);
        pipe_tag_d[0] = x_q;
        for (int k = 1; k < RESP_LAT; k++) begin
            pipe_vld_d[k] = pipe_vld_q[k-1];
            pipe_tag_d[k] = pipe_tag_q[k-1];
        end
    end

    always_comb begin
        pipe_inner = 1'b0;
        for (int k = 0; k < RESP_LAT - 1; k++) begin
            pipe_inner = pipe_inner | pipe_vld_q[k];
        end
    end

    assign emit_vld = pipe_vld_q[RESP_LAT-1];
    assign emit_tag = pipe_tag_q[RESP_LAT-1];

    // Shadow is held at zero outside SCAN/DRAIN, so every row's SCAN starts clean.
    always_comb begin
        shd_head_d = shd_head_q;
        shd_body_d = shd_body_q;
        if ((state_q != SCAN) && (state_q != DRAIN)) begin
            shd_head_d = '0;
            shd_body_d = '0;
        end else if (emit_vld) begin
            shd_head_d[emit_tag] = snakeHead;
            shd_body_d[emit_tag] = snakeBody;
        end
    end

    always_comb begin
        state_d     = state_q;
        x_d         = '0;
        y_d         = '0;
        row_cnt_d   = row_cnt_q;
        row_idx_d   = row_idx_q;
        head_row_d  = head_row_q;
        body_row_d  = body_row_q;
        row_valid_d = row_valid_q;
        sync_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SCAN;
                    row_cnt_d = '0;
                end
            end
            SCAN: begin
                if (x_q == X_LAST) begin
                    state_d = DRAIN;
                end else begin
                    x_d = x_q + 4'd1;
                    y_d = row_cnt_q;
                end
            end
            DRAIN: begin
                // Last response is emerging this cycle; take it via the shadow's next value.
                if (!pipe_inner) begin
                    state_d     = PRESENT;
                    head_row_d  = shd_head_d;
                    body_row_d  = shd_body_d;
                    row_idx_d   = row_cnt_q;
                    row_valid_d = 1'b1;
                end
            end
            PRESENT: begin
                if (row_if.row_ready) begin
                    row_valid_d = 1'b0;
                    if (row_cnt_q < Y_LAST) begin
                        state_d   = SCAN;
                        row_cnt_d = row_cnt_q + 4'd1;
                        y_d       = row_cnt_q + 4'd1;
                    end else begin
                        state_d = DONE;
                        sync_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign x                = x_q;
    assign y                = y_q;
    assign sync             = sync_q;
    assign busy             = (state_q != IDLE);
    assign row_if.head_row  = head_row_q;
    assign row_if.body_row  = body_row_q;
    assign row_if.row_idx   = row_idx_q;
    assign row_if.row_valid = row_valid_q;

`ifdef SNAKE_SCAN_HEAD_TRACK_EN
    logic       frame_start;
    logic       frame_end;
    logic [1:0] hcnt_q, hcnt_d;
    logic [3:0] hx_q, hx_d;
    logic [3:0] hy_q, hy_d;
    logic [3:0] head_x_q, head_x_d;
    logic [3:0] head_y_q, head_y_d;
    logic       head_err_q, head_err_d;

    assign frame_start = (state_q == IDLE) && start;
    assign frame_end   = (state_q == PRESENT) && row_if.row_ready && !(row_cnt_q < Y_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q     <= '0;
            hx_q       <= '0;
            hy_q       <= '0;
            head_x_q   <= '0;
            head_y_q   <= '0;
            head_err_q <= 1'b0;
        end else begin
            hcnt_q     <= hcnt_d;
            hx_q       <= hx_d;
            hy_q       <= hy_d;
            head_x_q   <= head_x_d;
            head_y_q   <= head_y_d;
            head_err_q <= head_err_d;
        end
    end

    // Count saturates at 2: only "exactly one head" matters.
    always_comb begin
        hcnt_d     = hcnt_q;
        hx_d       = hx_q;
        hy_d       = hy_q;
        head_x_d   = head_x_q;
        head_y_d   = head_y_q;
        head_err_d = head_err_q;
        if (frame_start) begin
            hcnt_d = '0;
            hx_d   = '0;
            hy_d   = '0;
        end else if (emit_vld && snakeHead) begin
            hx_d   = emit_tag;
            hy_d   = row_cnt_q;
            hcnt_d = (hcnt_q == 2'd2) ? 2'd2 : hcnt_q + 2'd1;
        end
        if (frame_end) begin
            head_x_d   = hx_q;
            head_y_d   = hy_q;
            head_err_d = (hcnt_q != 2'd1);
        end
    end

    assign head_x   = head_x_q;
    assign head_y   = head_y_q;
    assign head_err = head_err_q;
`else
    assign head_x   = '0;
    assign head_y   = '0;
    assign head_err = 1'b0;
`endif

endmodule

// File: tb/tb_snake_frame_scanner.sv
// Randomized self-checking bench for snake_frame_scanner: a grid model plays the body
// controller, expected rows and head results are derived from the grid itself.
module tb_snake_frame_scanner;

    localparam int GW = 16;
    localparam int GH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       start_b = 1'b0;
    logic [3:0] x_a, y_a, x_b, y_b;
    logic       snk_head_a = 1'b0, snk_body_a = 1'b0;
    logic       snk_head_b = 1'b0, snk_body_b = 1'b0;
    logic       sync_a, busy_a, sync_b, busy_b;
    logic [3:0] hx_a, hy_a, hx_b, hy_b;
    logic       herr_a, herr_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bit       head_map [16][16];
    bit       body_map [16][16];
    bit [7:0] hist_a [4];
    bit [7:0] hist_b [4];

    logic [3:0]  cap_idx [$];
    logic [15:0] cap_head [$];
    logic [15:0] cap_body [$];

    snake_frame_scanner_if #(.GRID_W(GW)) row_a ();
    snake_frame_scanner_if #(.GRID_W(GW)) row_b ();

    snake_frame_scanner #(.GRID_W(GW), .GRID_H(GH), .RESP_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .x(x_a), .y(y_a),
        .snakeHead(snk_head_a), .snakeBody(snk_body_a), .row_if(row_a),
        .sync(sync_a), .busy(busy_a), .head_x(hx_a), .head_y(hy_a), .head_err(herr_a)
    );

    snake_frame_scanner #(.GRID_W(GW), .GRID_H(GH), .RESP_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .x(x_b), .y(y_b),
        .snakeHead(snk_head_b), .snakeBody(snk_body_b), .row_if(row_b),
        .sync(sync_b), .busy(busy_b), .head_x(hx_b), .head_y(hy_b), .head_err(herr_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Body controller model: answers the query seen RESP_LAT cycles earlier.
    always @(negedge clk) begin
        for (int k = 3; k > 0; k--) begin
            hist_a[k] = hist_a[k-1];
            hist_b[k] = hist_b[k-1];
        end
        hist_a[0]  = {y_a, x_a};
        hist_b[0]  = {y_b, x_b};
        snk_head_a = head_map[hist_a[1][7:4]][hist_a[1][3:0]];
        snk_body_a = body_map[hist_a[1][7:4]][hist_a[1][3:0]];
        snk_head_b = head_map[hist_b[3][7:4]][hist_b[3][3:0]];
        snk_body_b = body_map[hist_b[3][7:4]][hist_b[3][3:0]];
    end

    function automatic logic [15:0] exp_row(input int r, input bit want_head);
        logic [15:0] v;
        v = '0;
        for (int c = 0; c < GW; c++) begin
            if (want_head ? head_map[r][c] : body_map[r][c]) v[c] = 1'b1;
        end
        return v;
    endfunction

    task automatic clear_maps();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                head_map[r][c] = 1'b0;
                body_map[r][c] = 1'b0;
            end
    endtask

    task automatic random_maps(input int nheads);
        clear_maps();
        for (int r = 0; r < GH; r++)
            for (int c = 0; c < GW; c++)
                body_map[r][c] = ($urandom_range(0, 7) == 0);
        for (int h = 0; h < nheads; h++)
            head_map[$urandom_range(0, GH-1)][$urandom_range(0, GW-1)] = 1'b1;
    endtask

    // Runs one frame on dut_a, recording accepted rows; no judgement made here.
    task automatic run_frame(input int stall_pct, output int n_sync, output int first_lat,
                             output logic [7:0] first_xy, output int stall_viol, output bit timed_out);
        int          t0;
        int          budget;
        bit          seen_valid;
        bit          prev_hold;
        logic [35:0] prev_row;
        cap_idx.delete();
        cap_head.delete();
        cap_body.delete();
        n_sync = 0; first_lat = -1; stall_viol = 0; timed_out = 1'b0;
        seen_valid = 1'b0; prev_hold = 1'b0; prev_row = '0; budget = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        t0 = cyc;
        first_xy = {y_a, x_a};
        while (busy_a && budget < 4000) begin
            if (sync_a) n_sync++;
            if (prev_hold && (!row_a.row_valid ||
                {row_a.row_idx, row_a.head_row, row_a.body_row} != prev_row)) stall_viol++;
            prev_hold = 1'b0;
            row_a.row_ready = 1'b0;
            if (row_a.row_valid) begin
                if (!seen_valid) begin
                    first_lat  = cyc - t0;
                    seen_valid = 1'b1;
                end
                if (int'($urandom_range(0, 99)) >= stall_pct) begin
                    row_a.row_ready = 1'b1;
                    cap_idx.push_back(row_a.row_idx);
                    cap_head.push_back(row_a.head_row);
                    cap_body.push_back(row_a.body_row);
                end else begin
                    prev_hold = 1'b1;
                    prev_row  = {row_a.row_idx, row_a.head_row, row_a.body_row};
                end
            end
            @(negedge clk);
            budget++;
        end
        if (budget >= 4000) timed_out = 1'b1;
        row_a.row_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0d want 0", busy_a); end
        checks++; if ({x_a, y_a} !== 8'h00) begin errors++; $display("FAIL reset_xy: got %0h want 0", {x_a, y_a}); end
        checks++; if (row_a.row_valid !== 1'b0) begin errors++; $display("FAIL reset_row_valid: got %0d want 0", row_a.row_valid); end
        checks++; if (sync_a !== 1'b0) begin errors++; $display("FAIL reset_sync: got %0d want 0", sync_a); end
        checks++; if ({row_a.row_idx, row_a.head_row, row_a.body_row} !== 36'h0) begin
            errors++; $display("FAIL reset_row_data: got %0h want 0", {row_a.row_idx, row_a.head_row, row_a.body_row}); end
        checks++; if ({hx_a, hy_a, herr_a} !== 9'h0) begin errors++; $display("FAIL reset_head: got %0h want 0", {hx_a, hy_a, herr_a}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_spec_frame();
        int n_sync, lat, viol; logic [7:0] fxy; bit to;
        clear_maps();
        head_map[3][5] = 1'b1;
        body_map[3][4] = 1'b1;
        body_map[3][3] = 1'b1;
        run_frame(0, n_sync, lat, fxy, viol, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL spec_timeout: got %0d want 0", to); end
        checks++; if (n_sync != 1) begin errors++; $display("FAIL spec_sync_count: got %0d want 1", n_sync); end
        checks++; if (fxy !== 8'h00) begin errors++; $display("FAIL spec_first_xy: got %0h want 0", fxy); end
        checks++; if (lat != GW + 1) begin errors++; $display("FAIL spec_row_latency: got %0d want %0d", lat, GW + 1); end
        checks++; if (cap_idx.size() != GH) begin errors++; $display("FAIL spec_row_count: got %0d want %0d", cap_idx.size(), GH); end
        for (int r = 0; r < cap_idx.size(); r++) begin
            checks++;
            if (cap_idx[r] !== 4'(r) || cap_head[r] !== exp_row(r, 1'b1) || cap_body[r] !== exp_row(r, 1'b0)) begin
                errors++;
                $display("FAIL spec_row%0d: got idx %0d head %h body %h want idx %0d head %h body %h",
                         r, cap_idx[r], cap_head[r], cap_body[r], r, exp_row(r, 1'b1), exp_row(r, 1'b0));
            end
        end
        if (cap_idx.size() > 3) begin
            checks++;
            if (cap_head[3] !== 16'h0020 || cap_body[3] !== 16'h0018) begin
                errors++; $display("FAIL spec_row3_const: got head %h body %h want 0020 0018", cap_head[3], cap_body[3]);
            end
        end
`ifdef SNAKE_SCAN_HEAD_TRACK_EN
        checks++; if ({hx_a, hy_a, herr_a} !== {4'd5, 4'd3, 1'b0}) begin
            errors++; $display("FAIL spec_head_track: got x %0d y %0d err %0d want 5 3 0", hx_a, hy_a, herr_a); end
`else
        checks++; if ({hx_a, hy_a, herr_a} !== 9'h0) begin
            errors++; $display("FAIL spec_head_track_off: got x %0d y %0d err %0d want 0 0 0", hx_a, hy_a, herr_a); end
`endif
    endtask

    task automatic test_no_head();
        int n_sync, lat, viol; logic [7:0] fxy; bit to;
        random_maps(0);
        run_frame(0, n_sync, lat, fxy, viol, to);
        checks++; if (n_sync != 1 || to) begin errors++; $display("FAIL nohead_frame: got sync %0d timeout %0d want 1 0", n_sync, to); end
`ifdef SNAKE_SCAN_HEAD_TRACK_EN
        checks++; if (herr_a !== 1'b1) begin errors++; $display("FAIL nohead_err: got %0d want 1", herr_a); end
`else
        checks++; if (herr_a !== 1'b0) begin errors++; $display("FAIL nohead_err_off: got %0d want 0", herr_a); end
`endif
    endtask

    task automatic test_backpressure();
        int budget;
        logic [15:0] eh, eb;
        random_maps(1);
        eh = exp_row(0, 1'b1);
        eb = exp_row(0, 1'b0);
        row_a.row_ready = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        budget = 0;
        while (!row_a.row_valid && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        checks++; if (row_a.row_valid !== 1'b1) begin errors++; $display("FAIL bp_first_row: got %0d want 1", row_a.row_valid); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (row_a.row_valid !== 1'b1 || row_a.row_idx !== 4'd0 || row_a.head_row !== eh ||
                row_a.body_row !== eb || {x_a, y_a} !== 8'h00) begin
                errors++;
                $display("FAIL bp_hold%0d: got v %0d idx %0d head %h body %h xy %h want 1 0 %h %h 00",
                         i, row_a.row_valid, row_a.row_idx, row_a.head_row, row_a.body_row, {x_a, y_a}, eh, eb);
            end
            @(negedge clk);
        end
        row_a.row_ready = 1'b1;
        @(negedge clk);
        row_a.row_ready = 1'b0;
        checks++;
        if (busy_a !== 1'b1 || x_a !== 4'd0 || y_a !== 4'd1 || row_a.row_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_next_scan: got busy %0d x %0d y %0d v %0d want 1 0 1 0", busy_a, x_a, y_a, row_a.row_valid);
        end
        row_a.row_ready = 1'b1;
        budget = 0;
        while (busy_a && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        row_a.row_ready = 1'b0;
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL bp_finish: got busy %0d want 0", busy_a); end
    endtask

    task automatic test_random();
        int n_sync, lat, viol, hcnt, lx, ly; logic [7:0] fxy; bit to;
        for (int it = 0; it < 4; it++) begin
            random_maps(int'($urandom_range(0, 2)));
            hcnt = 0; lx = 0; ly = 0;
            for (int r = 0; r < GH; r++)
                for (int c = 0; c < GW; c++)
                    if (head_map[r][c]) begin hcnt++; lx = c; ly = r; end
            run_frame(40, n_sync, lat, fxy, viol, to);
            checks++; if (to !== 1'b0 || n_sync != 1) begin
                errors++; $display("FAIL rand%0d_frame: got timeout %0d sync %0d want 0 1", it, to, n_sync); end
            checks++; if (viol != 0) begin errors++; $display("FAIL rand%0d_stall_stable: got %0d changes want 0", it, viol); end
            checks++; if (cap_idx.size() != GH) begin
                errors++; $display("FAIL rand%0d_row_count: got %0d want %0d", it, cap_idx.size(), GH); end
            for (int r = 0; r < cap_idx.size(); r++) begin
                checks++;
                if (cap_idx[r] !== 4'(r) || cap_head[r] !== exp_row(r, 1'b1) || cap_body[r] !== exp_row(r, 1'b0)) begin
                    errors++;
                    $display("FAIL rand%0d_row%0d: got idx %0d head %h body %h want idx %0d head %h body %h",
                             it, r, cap_idx[r], cap_head[r], cap_body[r], r, exp_row(r, 1'b1), exp_row(r, 1'b0));
                end
            end
`ifdef SNAKE_SCAN_HEAD_TRACK_EN
            checks++; if (herr_a !== (hcnt != 1)) begin
                errors++; $display("FAIL rand%0d_head_err: got %0d want %0d", it, herr_a, (hcnt != 1)); end
            if (hcnt > 0) begin
                checks++; if (hx_a !== 4'(lx) || hy_a !== 4'(ly)) begin
                    errors++; $display("FAIL rand%0d_head_pos: got %0d,%0d want %0d,%0d", it, hx_a, hy_a, lx, ly); end
            end
`else
            checks++; if ({hx_a, hy_a, herr_a} !== 9'h0) begin
                errors++; $display("FAIL rand%0d_head_off: got %0h want 0", it, {hx_a, hy_a, herr_a}); end
`endif
        end
    endtask

    task automatic test_start_ignored();
        int budget, n_sync, busy_after; bit done_seen;
        random_maps(1);
        n_sync = 0; busy_after = 0; done_seen = 1'b0; budget = 0;
        row_a.row_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (!done_seen && budget < 4000) begin
            if (sync_a) begin
                n_sync++;
                start = 1'b1;
                done_seen = 1'b1;
            end else begin
                start = ($urandom_range(0, 3) == 0);
            end
            @(negedge clk);
            budget++;
        end
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy_a) busy_after++;
            if (sync_a) n_sync++;
            @(negedge clk);
        end
        row_a.row_ready = 1'b0;
        checks++; if (n_sync != 1) begin errors++; $display("FAIL start_ign_sync: got %0d want 1", n_sync); end
        checks++; if (busy_after != 0) begin errors++; $display("FAIL start_ign_restart: got %0d busy cycles want 0", busy_after); end
    endtask

    task automatic test_reset_mid();
        int budget, syncs, n_sync, lat, viol; logic [7:0] fxy; bit to;
        random_maps(1);
        syncs = 0; budget = 0;
        row_a.row_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (!(busy_a && y_a == 4'd7) && budget < 2000) begin
            if (sync_a) syncs++;
            @(negedge clk);
            budget++;
        end
        checks++; if (y_a !== 4'd7) begin errors++; $display("FAIL rstmid_reach_y7: got %0d want 7", y_a); end
        rst = 1'b1;
        @(negedge clk);
        if (sync_a) syncs++;
        checks++;
        if (busy_a !== 1'b0 || {x_a, y_a} !== 8'h00 || row_a.row_valid !== 1'b0 || sync_a !== 1'b0 ||
            {row_a.row_idx, row_a.head_row, row_a.body_row} !== 36'h0 || {hx_a, hy_a, herr_a} !== 9'h0) begin
            errors++;
            $display("FAIL rstmid_outputs: got busy %0d xy %h v %0d sync %0d row %h head %h want all 0",
                     busy_a, {x_a, y_a}, row_a.row_valid, sync_a,
                     {row_a.row_idx, row_a.head_row, row_a.body_row}, {hx_a, hy_a, herr_a});
        end
        rst = 1'b0;
        row_a.row_ready = 1'b0;
        checks++; if (syncs != 0) begin errors++; $display("FAIL rstmid_no_sync: got %0d want 0", syncs); end
        run_frame(20, n_sync, lat, fxy, viol, to);
        checks++; if (fxy !== 8'h00 || n_sync != 1 || to) begin
            errors++; $display("FAIL rstmid_restart: got xy %h sync %0d timeout %0d want 00 1 0", fxy, n_sync, to); end
        checks++; if (cap_idx.size() != GH) begin
            errors++; $display("FAIL rstmid_rows: got %0d want %0d", cap_idx.size(), GH); end
        else if (cap_idx[0] !== 4'd0 || cap_body[0] !== exp_row(0, 1'b0)) begin
            errors++; $display("FAIL rstmid_row0: got idx %0d body %h want 0 %h", cap_idx[0], cap_body[0], exp_row(0, 1'b0)); end
    endtask

    task automatic test_resp_lat3();
        int t0, lat, budget, n_sync, nrows, bad_rows;
        logic [15:0] last_body;
        clear_maps();
        body_map[15][15] = 1'b1;
        lat = -1; budget = 0; n_sync = 0; nrows = 0; bad_rows = 0; last_body = '0;
        row_b.row_ready = 1'b1;
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        t0 = cyc;
        while (busy_b && budget < 2000) begin
            if (sync_b) n_sync++;
            if (row_b.row_valid) begin
                if (lat < 0) lat = cyc - t0;
                if (row_b.row_idx !== 4'(nrows) || row_b.head_row !== 16'h0) bad_rows++;
                if (nrows == GH - 1) last_body = row_b.body_row;
                else if (row_b.body_row !== 16'h0) bad_rows++;
                nrows++;
            end
            @(negedge clk);
            budget++;
        end
        checks++; if (lat != 19) begin errors++; $display("FAIL lat3_first_row: got %0d want 19", lat); end
        checks++; if (nrows != GH) begin errors++; $display("FAIL lat3_row_count: got %0d want %0d", nrows, GH); end
        checks++; if (last_body !== 16'h8000) begin errors++; $display("FAIL lat3_last_body: got %h want 8000", last_body); end
        checks++; if (bad_rows != 0) begin errors++; $display("FAIL lat3_other_rows: got %0d bad want 0", bad_rows); end
        checks++; if (n_sync != 1 || busy_b) begin
            errors++; $display("FAIL lat3_done: got sync %0d busy %0d want 1 0", n_sync, busy_b); end
    endtask

    initial begin
        row_a.row_ready = 1'b0;
        row_b.row_ready = 1'b1;
        test_reset();
        test_spec_frame();
        test_no_head();
        test_backpressure();
        test_random();
        test_start_ignored();
        test_reset_mid();
        test_resp_lat3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
